// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared FSM encoding, exception codes, interrupt cause and mtvec modes for trap_ctrl
package trap_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_TRAP       = 2'd1,
      ST_REDIR_TRAP = 2'd2,
      ST_REDIR_MRET = 2'd3
   } state_e;
   localparam logic [3:0] EXC_FETCH_MISALIGNED = 4'd0;
   localparam logic [3:0] EXC_ILLEGAL          = 4'd2;
   localparam logic [3:0] EXC_EBREAK           = 4'd3;
   localparam logic [3:0] EXC_ECALL            = 4'd11;
   localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;
   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;
   // Vectored interrupts land at base + 4*cause_code; the timer is code 7.
   localparam logic [31:0] TIMER_VEC_OFFSET = 32'd28;
   function automatic logic [31:0] trap_vector(input logic [31:0] mtvec, input logic is_irq);
      logic [31:0] base;
      base = {mtvec[31:2], 2'b00};
      return (is_irq && mtvec[1:0] == MTVEC_VECTORED) ? base + TIMER_VEC_OFFSET : base;
   endfunction
endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/MRET sequencer driving CSR trap writes, pipeline flush and fetch redirect
//   in : clk, rst_n (async, active-low), exc_valid/exc_code/exc_pc, mret_valid,
//        commit_valid/commit_pc, irq_timer, mstatus_mie, mtvec, mepc
//   out: trap_en/trap_pc/trap_cause (to CSR file), flush, redirect_valid/redirect_pc, busy
module trap_ctrl
   import trap_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exc_valid,
   input  logic [3:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        mret_valid,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        irq_timer,
   input  logic        mstatus_mie,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        trap_en,
   output logic [31:0] trap_pc,
   output logic [31:0] trap_cause,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);
   state_e      state_q, state_d;
   logic        in_handler_q, in_handler_d;
   logic        is_irq_q, is_irq_d;
   logic        trap_en_q, trap_en_d;
   logic        flush_q, flush_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic        busy_q, busy_d;
   logic [31:0] trap_pc_q, trap_pc_d;
   logic [31:0] trap_cause_q, trap_cause_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        take_irq;

   assign take_irq = irq_timer & mstatus_mie & commit_valid & ~in_handler_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_IDLE;
         in_handler_q     <= 1'b0;
         is_irq_q         <= 1'b0;
         trap_en_q        <= 1'b0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         busy_q           <= 1'b0;
         trap_pc_q        <= '0;
         trap_cause_q     <= '0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         in_handler_q     <= in_handler_d;
         is_irq_q         <= is_irq_d;
         trap_en_q        <= trap_en_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         busy_q           <= busy_d;
         trap_pc_q        <= trap_pc_d;
         trap_cause_q     <= trap_cause_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      in_handler_d     = in_handler_q;
      is_irq_d         = is_irq_q;
      trap_en_d        = 1'b0;
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      trap_pc_d        = trap_pc_q;
      trap_cause_d     = trap_cause_q;
      redirect_pc_d    = redirect_pc_q;
      case (state_q)
         ST_IDLE: begin
            if (exc_valid) begin
               state_d      = ST_TRAP;
               trap_en_d    = 1'b1;
               flush_d      = 1'b1;
               trap_pc_d    = exc_pc;
               trap_cause_d = {28'b0, exc_code};
               in_handler_d = 1'b1;
               is_irq_d     = 1'b0;
            end else if (mret_valid) begin
               state_d          = ST_REDIR_MRET;
               flush_d          = 1'b1;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = mepc;
               in_handler_d     = 1'b0;
            end else if (take_irq) begin
               // The committing instruction is not retired, so mepc points back at it.
               state_d      = ST_TRAP;
               trap_en_d    = 1'b1;
               flush_d      = 1'b1;
               trap_pc_d    = commit_pc;
               trap_cause_d = CAUSE_TIMER_IRQ;
               in_handler_d = 1'b1;
               is_irq_d     = 1'b1;
            end
         end
         ST_TRAP: begin
            // mtvec is read here, one cycle late, so a CSR write landing alongside the trap is honoured.
            state_d          = ST_REDIR_TRAP;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = trap_vector(mtvec, is_irq_q);
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign trap_en        = trap_en_q;
   assign trap_pc        = trap_pc_q;
   assign trap_cause     = trap_cause_q;
   assign flush          = flush_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed literal checks plus randomized run against a queue-based reference model
module tb_trap_ctrl;
   import trap_ctrl_pkg::*;
   logic        clk, rst_n;
   logic        exc_valid, mret_valid, commit_valid, irq_timer, mstatus_mie;
   logic [3:0]  exc_code;
   logic [31:0] exc_pc, commit_pc, mtvec, mepc;
   logic        trap_en, flush, redirect_valid, busy;
   logic [31:0] trap_pc, trap_cause, redirect_pc;

   int n_cmp = 0;
   int n_fail = 0;
   int pulses;

   trap_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
      .mret_valid(mret_valid), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .irq_timer(irq_timer), .mstatus_mie(mstatus_mie), .mtvec(mtvec), .mepc(mepc),
      .trap_en(trap_en), .trap_pc(trap_pc), .trap_cause(trap_cause), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted event queues the remaining busy cycles it occupies.
   // 1 = cycle that issues the trap redirect, 0 = a quiet busy cycle.
   int          pend[$];
   logic        m_trap_en, m_flush, m_rv, m_busy, m_inh, m_irq;
   logic [31:0] m_tpc, m_tcause, m_rpc;

   function automatic logic [31:0] ref_vector(input logic [31:0] tv, input logic irq);
      logic [31:0] r;
      r = tv & ~32'd3;
      if (irq && (tv % 4) == 1) r = r + 4 * 7;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend.delete();
         {m_trap_en, m_flush, m_rv, m_busy, m_inh, m_irq} = '0;
         m_tpc = 0; m_tcause = 0; m_rpc = 0;
      end else begin
         m_trap_en = 0; m_flush = 0; m_rv = 0;
         if (pend.size() > 0) begin
            if (pend.pop_front() == 1) begin
               m_rv  = 1;
               m_rpc = ref_vector(mtvec, m_irq);
            end
         end else if (exc_valid) begin
            m_trap_en = 1; m_flush = 1; m_tpc = exc_pc; m_tcause = 32'(exc_code);
            m_inh = 1; m_irq = 0;
            pend.push_back(1); pend.push_back(0);
         end else if (mret_valid) begin
            m_flush = 1; m_rv = 1; m_rpc = mepc; m_inh = 0;
            pend.push_back(0);
         end else if (irq_timer && mstatus_mie && commit_valid && !m_inh) begin
            m_trap_en = 1; m_flush = 1; m_tpc = commit_pc; m_tcause = 32'h8000_0007;
            m_inh = 1; m_irq = 1;
            pend.push_back(1); pend.push_back(0);
         end
         m_busy = (pend.size() != 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("m_trap_en", 32'(trap_en), 32'(m_trap_en));
         check("m_flush", 32'(flush), 32'(m_flush));
         check("m_redirect_valid", 32'(redirect_valid), 32'(m_rv));
         check("m_busy", 32'(busy), 32'(m_busy));
         check("m_trap_pc", trap_pc, m_tpc);
         check("m_trap_cause", trap_cause, m_tcause);
         check("m_redirect_pc", redirect_pc, m_rpc);
      end
   end

   task automatic quiet();
      exc_valid = 0; mret_valid = 0; commit_valid = 0; irq_timer = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_trap_en"}, 32'(trap_en), 0);
      check({tag, "_flush"}, 32'(flush), 0);
      check({tag, "_redirect_valid"}, 32'(redirect_valid), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_trap_pc"}, trap_pc, 0);
      check({tag, "_trap_cause"}, trap_cause, 0);
      check({tag, "_redirect_pc"}, redirect_pc, 0);
   endtask

   initial begin
      quiet();
      rst_n = 0; mstatus_mie = 0; exc_code = 0; exc_pc = 0; commit_pc = 0; mtvec = 0; mepc = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1;
      @(negedge clk);
      // Illegal-instruction exception, direct vector
      exc_valid = 1; exc_code = EXC_ILLEGAL; exc_pc = 32'h100; mtvec = 32'h200;
      @(negedge clk); quiet();
      check("exc_trap_en", 32'(trap_en), 1);
      check("exc_flush", 32'(flush), 1);
      check("exc_trap_pc", trap_pc, 32'h100);
      check("exc_cause", trap_cause, 2);
      @(negedge clk);
      check("exc_redir_valid", 32'(redirect_valid), 1);
      check("exc_redir_pc", redirect_pc, 32'h200);
      @(negedge clk);
      check("exc_idle", 32'(busy), 0);
      mret_valid = 1; mepc = 32'h104;
      @(negedge clk); quiet();
      check("mret1_pc", redirect_pc, 32'h104);
      @(negedge clk);
      // Vectored timer interrupt
      irq_timer = 1; mstatus_mie = 1; commit_valid = 1; commit_pc = 32'h44; mtvec = 32'h301;
      @(negedge clk);
      check("irq_trap_en", 32'(trap_en), 1);
      check("irq_cause", trap_cause, 32'h8000_0007);
      check("irq_trap_pc", trap_pc, 32'h44);
      @(negedge clk);
      check("irq_redir_pc", redirect_pc, 32'h31C);
      // Level interrupt stays high inside the handler: no re-entry
      pulses = 0;
      repeat (4) begin @(negedge clk); pulses += int'(trap_en); end
      check("irq_no_reentry", pulses, 0);
      mret_valid = 1; mepc = 32'h44;
      @(negedge clk); mret_valid = 0;
      check("mret2_pc", redirect_pc, 32'h44);
      check("mret2_flush", 32'(flush), 1);
      check("mret2_trap_en", 32'(trap_en), 0);
      @(negedge clk);
      @(negedge clk);
      check("irq_retaken", 32'(trap_en), 1);
      quiet();
      repeat (3) @(negedge clk);
      // Exception and MRET together: exception wins
      exc_valid = 1; mret_valid = 1; exc_code = EXC_ECALL; exc_pc = 32'h500; mepc = 32'h999; mtvec = 32'h200;
      @(negedge clk); quiet();
      check("both_trap_en", 32'(trap_en), 1);
      check("both_cause", trap_cause, 11);
      @(negedge clk);
      check("both_redir_pc", redirect_pc, 32'h200);
      @(negedge clk);
      check("both_idle", 32'(busy), 0);
      // Repeated exception while busy is ignored
      exc_valid = 1; exc_code = EXC_EBREAK; exc_pc = 32'h600;
      pulses = 0;
      @(negedge clk); pulses += int'(trap_en); exc_code = EXC_FETCH_MISALIGNED; exc_pc = 32'h700;
      @(negedge clk); pulses += int'(trap_en); exc_valid = 0;
      repeat (3) begin @(negedge clk); pulses += int'(trap_en); end
      check("busy_single_pulse", pulses, 1);
      check("busy_trap_pc", trap_pc, 32'h600);
      // Reset while in TRAP
      exc_valid = 1; exc_pc = 32'h800;
      @(negedge clk); quiet();
      check("rst_pre_trap_en", 32'(trap_en), 1);
      #2 rst_n = 0;
      #1 check_all_zero("midrst");
      @(negedge clk); rst_n = 1;
      pulses = 0;
      repeat (5) begin @(negedge clk); pulses += int'(trap_en) + int'(redirect_valid) + int'(flush); end
      check("post_rst_quiet", pulses, 0);
      // Randomized run
      repeat (3000) begin
         @(negedge clk);
         exc_valid = ($urandom_range(0, 7) == 0);
         mret_valid = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0: exc_code = EXC_FETCH_MISALIGNED;
            1: exc_code = EXC_ILLEGAL;
            2: exc_code = EXC_EBREAK;
            default: exc_code = EXC_ECALL;
         endcase
         exc_pc = $urandom; commit_pc = $urandom; mepc = $urandom;
         commit_valid = ($urandom_range(0, 3) != 0);
         mstatus_mie = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) irq_timer = ~irq_timer;
         mtvec = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF1 : ($urandom & ~32'd2);
         if ($urandom_range(0, 499) == 0) begin
            #1 rst_n = 0;
            #2 rst_n = 1;
         end
      end
      quiet();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
